// File: rtl/flit_link_serializer.sv
// Buffers forwarded flits in a small FIFO and serializes each one onto a narrow
// link as LINK_WIDTH-bit beats (LSB first), followed by one XOR checksum beat.
//
// Ports:
//   nocclk, rst                      clock, synchronous active-high reset
//   forwarded_flit_valid/_ready      upstream flit handshake
//   forwarded_flit                   upstream flit payload
//   link_valid/link_ready            link beat handshake
//   link_data                        current beat (data or checksum)
//   link_sof / link_eof              first data beat / checksum beat of a frame
//   fifo_count                       flits held, including the one in flight
//   busy                             serializer is mid-frame
module flit_link_serializer #(
    parameter int unsigned FLIT_WIDTH = 64,
    parameter int unsigned LINK_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          nocclk,
    input  logic                          rst,
    input  logic                          forwarded_flit_valid,
    input  logic [FLIT_WIDTH-1:0]         forwarded_flit,
    output logic                          forwarded_flit_ready,
    output logic                          link_valid,
    output logic [LINK_WIDTH-1:0]         link_data,
    output logic                          link_sof,
    output logic                          link_eof,
    input  logic                          link_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
);

    localparam int unsigned BEATS  = FLIT_WIDTH / LINK_WIDTH;
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;
    localparam logic [FCNT_W-1:0] FULL      = FCNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_CSUM} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       beat_q, beat_d;
    logic [LINK_WIDTH-1:0]  csum_q, csum_d;
    logic [FLIT_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [FLIT_WIDTH-1:0]  mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]      count_q, count_d;
    logic                   ready_q, ready_d;
    logic                   valid_q, valid_d;
    logic [LINK_WIDTH-1:0]  data_q, data_d;
    logic                   sof_q, sof_d;
    logic                   eof_q, eof_d;
    logic                   busy_q, busy_d;
    logic [FLIT_WIDTH-1:0]  head_d;
    logic                   push, accept, pop;

    // FIFO bookkeeping, frame FSM and next-cycle link outputs
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        csum_d   = csum_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = 1'b0;
        data_d   = '0;
        sof_d    = 1'b0;
        eof_d    = 1'b0;

        push   = forwarded_flit_valid && ready_q;
        accept = valid_q && link_ready;
        pop    = (state_q == ST_CSUM) && accept;

        if (push) begin
            mem_d[wr_ptr_q] = forwarded_flit;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + FCNT_W'(1);
            2'b01:   count_d = count_q - FCNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (accept) begin
                    csum_d = csum_q ^ data_q;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = ST_CSUM;
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    csum_d  = '0;
                    beat_d  = '0;
                    // count_d already reflects the pop and any same-cycle push
                    state_d = (count_d != '0) ? ST_SEND : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // mem_d forwards a same-cycle push so a push-at-pop flit starts at once
        head_d  = mem_d[rd_ptr_d];
        valid_d = (state_d != ST_IDLE);
        if (state_d == ST_SEND) begin
            data_d = head_d[32'(beat_d) * LINK_WIDTH +: LINK_WIDTH];
            sof_d  = (beat_d == '0);
        end else if (state_d == ST_CSUM) begin
            data_d = csum_d;
            eof_d  = 1'b1;
        end
        ready_d = (count_d != FULL);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge nocclk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            csum_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            data_q   <= '0;
            sof_q    <= 1'b0;
            eof_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            csum_q   <= csum_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            sof_q    <= sof_d;
            eof_q    <= eof_d;
            busy_q   <= busy_d;
        end
    end

    // Flit storage needs no reset; entries are only read after being written
    always_ff @(posedge nocclk) begin
        mem_q <= mem_d;
    end

    assign forwarded_flit_ready = ready_q;
    assign link_valid           = valid_q;
    assign link_data            = data_q;
    assign link_sof             = sof_q;
    assign link_eof             = eof_q;
    assign fifo_count           = count_q;
    assign busy                 = busy_q;

    a_no_push_full: assert property (@(posedge nocclk) disable iff (rst)
        !(forwarded_flit_valid && forwarded_flit_ready && (fifo_count == FULL)));

    a_hold_stall: assert property (@(posedge nocclk) disable iff (rst)
        (link_valid && !link_ready) |=>
            ($stable(link_data) && $stable(link_sof) && $stable(link_eof)));

endmodule

// File: tb/tb_flit_link_serializer.sv
// Directed bench for flit_link_serializer (64-bit flits, 8-bit link, depth 4).
module tb_flit_link_serializer;

    localparam int unsigned FW = 64;
    localparam int unsigned LW = 8;
    localparam int unsigned BEATS = FW / LW;

    logic          nocclk;
    logic          rst;
    logic          fwd_valid;
    logic [FW-1:0] fwd_flit;
    logic          fwd_ready;
    logic          link_valid;
    logic [LW-1:0] link_data;
    logic          link_sof;
    logic          link_eof;
    logic          link_ready;
    logic [2:0]    fifo_count;
    logic          busy;

    int checks;
    int failures;

    flit_link_serializer #(.FLIT_WIDTH(FW), .LINK_WIDTH(LW), .FIFO_DEPTH(4)) dut (
        .nocclk               (nocclk),
        .rst                  (rst),
        .forwarded_flit_valid (fwd_valid),
        .forwarded_flit       (fwd_flit),
        .forwarded_flit_ready (fwd_ready),
        .link_valid           (link_valid),
        .link_data            (link_data),
        .link_sof             (link_sof),
        .link_eof             (link_eof),
        .link_ready           (link_ready),
        .fifo_count           (fifo_count),
        .busy                 (busy)
    );

    initial nocclk = 1'b0;
    always #5 nocclk = ~nocclk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one edge; outputs are sampled and inputs driven 1 time unit later
    task automatic step();
        @(posedge nocclk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_valid"}, 64'(link_valid), 64'd0);
        check_eq({tag, "_busy"},  64'(busy),       64'd0);
        check_eq({tag, "_count"}, 64'(fifo_count), 64'd0);
        check_eq({tag, "_ready"}, 64'(fwd_ready),  64'd1);
        check_eq({tag, "_data"},  64'(link_data),  64'd0);
    endtask

    // Expects beat 0 of a frame on the link; walks all data beats plus checksum.
    task automatic send_frame(input string tag, input logic [FW-1:0] flit, input logic [LW-1:0] csum,
                              input int stall_beat, input int stall_cycles,
                              input bit push_at_csum, input logic [FW-1:0] push_flit);
        logic [LW-1:0] exp;
        link_ready = 1'b1;
        for (int k = 0; k <= int'(BEATS); k++) begin
            exp = (k < int'(BEATS)) ? flit[k*LW +: LW] : csum;
            if (k == stall_beat) begin
                link_ready = 1'b0;
                for (int s = 0; s < stall_cycles; s++) begin
                    check_eq({tag, "_stall_valid"}, 64'(link_valid), 64'd1);
                    check_eq({tag, "_stall_data"},  64'(link_data),  64'(exp));
                    check_eq({tag, "_stall_sof"},   64'(link_sof),   64'(k == 0));
                    step();
                end
                link_ready = 1'b1;
            end
            check_eq({tag, "_valid"}, 64'(link_valid), 64'd1);
            check_eq({tag, "_data"},  64'(link_data),  64'(exp));
            check_eq({tag, "_sof"},   64'(link_sof),   64'(k == 0));
            check_eq({tag, "_eof"},   64'(link_eof),   64'(k == int'(BEATS)));
            if (k == int'(BEATS) && push_at_csum) begin
                fwd_valid = 1'b1;
                fwd_flit  = push_flit;
            end
            step();
            fwd_valid = 1'b0;
        end
    endtask

    // Push one flit into an idle serializer and wait until its first beat is shown
    task automatic load_one(input string tag, input logic [FW-1:0] flit);
        fwd_valid = 1'b1;
        fwd_flit  = flit;
        step();
        fwd_valid = 1'b0;
        check_eq({tag, "_cnt1"},    64'(fifo_count), 64'd1);
        check_eq({tag, "_novalid"}, 64'(link_valid), 64'd0);
        step();
    endtask

    initial begin
        logic [FW-1:0] g [5];
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        fwd_valid  = 1'b0;
        fwd_flit   = '0;
        link_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_idle("reset");
        check_eq("reset_sof", 64'(link_sof), 64'd0);
        check_eq("reset_eof", 64'(link_eof), 64'd0);

        // Single flit, checksum 01^02^..^08 = 08
        link_ready = 1'b1;
        load_one("single", 64'h0807060504030201);
        send_frame("single", 64'h0807060504030201, 8'h08, -1, 0, 1'b0, '0);
        check_idle("single_end");

        // Backpressure on beat 0x03 for 5 cycles
        load_one("bp", 64'h0807060504030201);
        send_frame("bp", 64'h0807060504030201, 8'h08, 2, 5, 1'b0, '0);
        check_idle("bp_end");

        // Fill FIFO with link stalled; 5th offer must be refused
        g[0] = 64'h00000000000000A1;
        g[1] = 64'h00000000B2000000;
        g[2] = 64'h0F00000000000030;
        g[3] = 64'hFFFFFFFFFFFFFFFF;
        g[4] = 64'hDEADBEEFCAFEF00D;
        link_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("full_ready_pre", 64'(fwd_ready), 64'(i < 4));
            fwd_valid = 1'b1;
            fwd_flit  = g[i];
            step();
        end
        fwd_valid = 1'b0;
        check_eq("full_count", 64'(fifo_count), 64'd4);
        check_eq("full_ready", 64'(fwd_ready),  64'd0);
        send_frame("full_g0", g[0], 8'hA1, -1, 0, 1'b0, '0);
        check_eq("full_ready_back", 64'(fwd_ready),  64'd1);
        check_eq("full_count3",     64'(fifo_count), 64'd3);
        send_frame("full_g1", g[1], 8'hB2, -1, 0, 1'b0, '0);
        send_frame("full_g2", g[2], 8'h3F, -1, 0, 1'b0, '0);
        send_frame("full_g3", g[3], 8'h00, -1, 0, 1'b0, '0);
        check_idle("full_end");

        // Back-to-back: two queued flits give 18 contiguous valid beats
        link_ready = 1'b1;
        fwd_valid  = 1'b1;
        fwd_flit   = 64'h5555555555555555;
        step();
        fwd_flit   = 64'h0102040810204080;
        step();
        fwd_valid  = 1'b0;
        check_eq("b2b_count", 64'(fifo_count), 64'd2);
        send_frame("b2b_h0", 64'h5555555555555555, 8'h00, -1, 0, 1'b0, '0);
        send_frame("b2b_h1", 64'h0102040810204080, 8'hFF, -1, 0, 1'b0, '0);
        check_idle("b2b_end");

        // Push in the same cycle the checksum beat is accepted
        load_one("pap", 64'h0000000000001234);
        send_frame("pap_p0", 64'h0000000000001234, 8'h26, -1, 0, 1'b1, 64'h8000000000000001);
        check_eq("pap_count", 64'(fifo_count), 64'd1);
        check_eq("pap_valid", 64'(link_valid), 64'd1);
        check_eq("pap_sof",   64'(link_sof),   64'd1);
        check_eq("pap_data",  64'(link_data),  64'h01);
        send_frame("pap_p1", 64'h8000000000000001, 8'h81, -1, 0, 1'b0, '0);
        check_idle("pap_end");

        // Reset while beat 0x04 is on the link
        load_one("rstm", 64'h0807060504030201);
        for (int k = 0; k < 3; k++) begin
            check_eq("rstm_pre_data", 64'(link_data), 64'(k + 1));
            step();
        end
        check_eq("rstm_beat4", 64'(link_data), 64'h04);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("rstm_after");
        check_eq("rstm_sof", 64'(link_sof), 64'd0);
        check_eq("rstm_eof", 64'(link_eof), 64'd0);
        load_one("rstm_new", 64'h1020304050607080);
        send_frame("rstm_new", 64'h1020304050607080, 8'h80, -1, 0, 1'b0, '0);
        check_idle("rstm_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flit_link_serializer.md
Name: flit_link_serializer

Overview:
- Downstream stage of the packet controller's forwarded-flit output.
- Buffers forwarded flits in a small FIFO and serializes each one onto a narrow inter-device link as LINK_WIDTH-bit beats, LSB first.
- Appends one XOR checksum beat per flit.
- Provides valid/ready backpressure on both sides.

Parameters:
FLIT_WIDTH, 64, width of one flit; must be an integer multiple of LINK_WIDTH.
LINK_WIDTH, 8, width of one link beat.
FIFO_DEPTH, 4, number of flits buffered; power of two, at least 2.

Ports:
nocclk  input  1  sole clock; all state changes on the rising edge.
rst  input  1  synchronous reset, active-high.
forwarded_flit_valid  input  1  upstream flit valid.
forwarded_flit  input  FLIT_WIDTH  upstream flit.
forwarded_flit_ready  output  1  FIFO can accept a flit this cycle.
link_valid  output  1  beat on link_data is valid.
link_data  output  LINK_WIDTH  current beat.
link_sof  output  1  marks the first data beat of a frame.
link_eof  output  1  marks the checksum beat (last beat of a frame).
link_ready  input  1  link partner accepts the beat this cycle.
fifo_count  output  $clog2(FIFO_DEPTH)+1  flits currently held, including the one being sent.
busy  output  1  FSM is not IDLE.

Behaviour:
- Reset (rst=1 at a clock edge):
  - FIFO emptied; FSM goes to IDLE.
  - Beat counter and checksum cleared.
  - Outputs after reset: link_valid=0, link_data=0, link_sof=0, link_eof=0, busy=0, fifo_count=0, forwarded_flit_ready=1.
  - A reset mid-frame aborts the frame; the partial frame is never resumed.
- Definitions: BEATS = FLIT_WIDTH/LINK_WIDTH. Beat k is flit[k*LINK_WIDTH +: LINK_WIDTH].
- Upstream handshake:
  - forwarded_flit_ready = (fifo_count != FIFO_DEPTH), driven from registered count only.
  - A pop in the same cycle does not raise ready.
  - Push happens when valid && ready.
  - Flit storage is a registered array with wrap-around read/write pointers.
- Flit ownership: a flit stays in the FIFO, and is counted, until its checksum beat is accepted. The head entry is popped at that point.
- FSM states: IDLE, SEND, CSUM.
- IDLE:
  - link_valid=0.
  - If fifo_count>0, go to SEND next cycle.
  - Latency: a flit pushed into an empty FIFO at edge t gives its first beat on link_valid in the cycle after edge t+1.
- SEND:
  - link_valid=1; link_data = beat[beat_cnt] of the head flit; link_sof = (beat_cnt==0).
  - On link_valid && link_ready: checksum ^= link_data and beat_cnt increments.
  - When beat BEATS-1 is accepted, go to CSUM.
  - If link_ready=0, link_data, link_sof and link_eof hold stable.
- CSUM:
  - link_valid=1; link_data = checksum, i.e. the XOR of all BEATS data beats; link_eof=1; link_sof=0.
  - On acceptance:
    - Pop the head and clear the checksum and beat_cnt.
    - Next state is SEND if (fifo_count - 1 + push_this_cycle) > 0, otherwise IDLE.
  - This gives zero-bubble back-to-back frames. A flit pushed in the same cycle as the pop is eligible.
- Simultaneous push and pop: fifo_count is unchanged. Pointer wrap-around at FIFO_DEPTH must be correct.
- link_data in IDLE: 0.
- busy: 1 in SEND or CSUM.
- Assertions for verification: no push when full; link_data/sof/eof stable while link_valid && !link_ready.

Test Plan:
- Single flit: 64/8 configuration, flit 0x0807060504030201, link_ready=1.
  - Beats 01,02,…,08 on consecutive cycles, sof on 01.
  - Then beat 0x08 with eof.
  - Then link_valid=0, busy=0, fifo_count=0.
- Backpressure: same flit, link_ready=0 for 5 cycles while beat 0x03 is presented.
  - link_data stays 0x03 with link_valid=1 throughout.
  - Remaining beats and checksum 0x08 follow unchanged.
- Full FIFO: link_ready=0, offer 5 flits back-to-back.
  - Exactly 4 accepted; forwarded_flit_ready=0 after the 4th; fifo_count=4.
  - After one full frame (9 beats) completes, ready returns to 1 the next cycle.
- Back-to-back: two flits queued, link_ready=1.
  - 18 consecutive valid cycles; sof on cycles 1 and 10, eof on cycles 9 and 18; no idle gap.
- Push at pop: FIFO holds 1 flit; push a new flit in the same cycle the checksum beat is accepted.
  - Next cycle is SEND of the new flit with sof=1; fifo_count remains 1.
- Reset mid-frame: assert rst during beat 4.
  - Next cycle link_valid=0, fifo_count=0, ready=1.
  - A fresh flit afterwards starts at beat 0 with sof=1 and the correct checksum.
